// File: rtl/mesh_term_injector.sv
// Terminal-side injection stage for one mesh_gnrtr input port: formats requests
// into mesh packets and queues them behind the router's pndng/data/popin handshake.
module mesh_term_injector #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMNS    = 4,
  parameter int unsigned PAKG_SIZE  = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  BDCST      = 8'hFF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_bcast,
  input  logic [3:0]                           in_row,
  input  logic [3:0]                           in_col,
  input  logic                                 in_mode,
  input  logic [PAKG_SIZE-18:0]                in_payload,
  input  logic                                 popin,
  output logic                                 pndng_i_in,
  output logic [PAKG_SIZE-1:0]                 data_out_i_in,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      level,
  output logic [15:0]                          tx_count,
  output logic                                 err_pop_empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH+1);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  // Row/column fields are 4 bits wide and the pointers rely on power-of-two wrap.
  if (ROWS > 15 || COLUMNS > 15 || PAKG_SIZE < 18 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("mesh_term_injector: unsupported parameterization");
  end

  logic [PAKG_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PAKG_SIZE-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [15:0]          tx_count_q, tx_count_d;
  logic                 err_q, err_d;
  logic [1:0]           state_q, state_d;

  logic                 push, pop_ok;
  logic [PAKG_SIZE-1:0] pkt;

  assign push   = in_valid && (state_q != ST_FULL);
  assign pop_ok = popin && (state_q != ST_EMPTY);
  assign pkt    = {(in_bcast ? BDCST : 8'h00), in_row, in_col, in_mode, in_payload};

  // Datapath next-state: a pop while empty only raises the sticky error.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    tx_count_d = tx_count_q;
    err_d      = err_q;
    if (push) begin
      mem_d[wr_ptr_q] = pkt;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      tx_count_d = tx_count_q + 16'd1;
    end
    if (popin && (state_q == ST_EMPTY)) begin
      err_d = 1'b1;
    end
    level_d = level_q + LVL_W'(push) - LVL_W'(pop_ok);
  end

  // Occupancy state mirrors level; it only exists to register the handshake flags.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (level_d == LVL_W'(FIFO_DEPTH))  state_d = ST_FULL;
        else if (level_d == LVL_W'(0))      state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (pop_ok) state_d = ST_ACTIVE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_count_q <= '0;
      err_q      <= 1'b0;
      state_q    <= ST_EMPTY;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tx_count_q <= tx_count_d;
      err_q      <= err_d;
      state_q    <= state_d;
    end
  end

  assign in_ready      = (state_q != ST_FULL);
  assign pndng_i_in    = (state_q != ST_EMPTY);
  assign data_out_i_in = mem_q[rd_ptr_q];
  assign level         = level_q;
  assign tx_count      = tx_count_q;
  assign err_pop_empty = err_q;

endmodule

// File: tb/tb_mesh_term_injector.sv
// Self-checking bench for mesh_term_injector: directed scenarios plus random
// traffic compared against a queue-based packet model.
module tb_mesh_term_injector;

  localparam int unsigned PS    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PW    = PS - 17;

  logic          clk, reset;
  logic          in_valid, in_ready, in_bcast, in_mode, popin;
  logic [3:0]    in_row, in_col;
  logic [PW-1:0] in_payload;
  logic          pndng_i_in, err_pop_empty;
  logic [PS-1:0] data_out_i_in;
  logic [4:0]    level;
  logic [15:0]   tx_count;

  mesh_term_injector #(.ROWS(4), .COLUMNS(4), .PAKG_SIZE(PS), .FIFO_DEPTH(DEPTH), .BDCST(8'hFF)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_bcast(in_bcast), .in_row(in_row), .in_col(in_col), .in_mode(in_mode),
    .in_payload(in_payload), .popin(popin), .pndng_i_in(pndng_i_in),
    .data_out_i_in(data_out_i_in), .level(level), .tx_count(tx_count),
    .err_pop_empty(err_pop_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [PS-1:0] model_q[$];
  int            m_tx  = 0;
  bit            m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [PS-1:0] fmt(input bit bc, input logic [3:0] r, input logic [3:0] c,
                                        input bit m, input logic [PW-1:0] p);
    logic [7:0] nj;
    nj = bc ? 8'hFF : 8'h00;
    return {nj, r, c, m, p};
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(model_q.size()));
    chk({tag, ".pndng"}, 32'(pndng_i_in), 32'(model_q.size() != 0));
    chk({tag, ".ready"}, 32'(in_ready), 32'(model_q.size() != DEPTH));
    chk({tag, ".tx"}, 32'(tx_count), 32'(m_tx[15:0]));
    chk({tag, ".err"}, 32'(err_pop_empty), 32'(m_err));
    if (model_q.size() != 0) chk({tag, ".data"}, data_out_i_in, model_q[0]);
  endtask

  // Called at a falling edge: drives one cycle, advances the model, checks at the next falling edge.
  task automatic cycle(input bit v, input bit bc, input logic [3:0] r, input logic [3:0] c,
                       input bit m, input logic [PW-1:0] p, input bit pop, input string tag);
    bit acc, pk;
    in_valid = v; in_bcast = bc; in_row = r; in_col = c; in_mode = m; in_payload = p; popin = pop;
    acc = v && (model_q.size() != DEPTH);
    pk  = pop && (model_q.size() != 0);
    if (pop && model_q.size() == 0) m_err = 1'b1;
    if (pk) begin
      void'(model_q.pop_front());
      m_tx++;
    end
    if (acc) model_q.push_back(fmt(bc, r, c, m, p));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; popin = 1'b0;
    check_model(tag);
  endtask

  task automatic push_p(input logic [PW-1:0] p, input string tag);
    cycle(1'b1, 1'b0, 4'd1, 4'd2, 1'b0, p, 1'b0, tag);
  endtask

  task automatic pop1(input string tag);
    cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, '0, 1'b1, tag);
  endtask

  task automatic model_reset();
    model_q.delete();
    m_tx = 0;
    m_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; in_row = '0; in_col = '0;
    in_mode = 1'b0; in_payload = '0; popin = 1'b0;
    @(negedge clk);
    chk("rst.level", 32'(level), 32'd0);
    chk("rst.pndng", 32'(pndng_i_in), 32'd0);
    chk("rst.data", data_out_i_in, 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.tx", 32'(tx_count), 32'd0);
    reset = 1'b0;

    // Basic unicast and broadcast formatting.
    cycle(1'b1, 1'b0, 4'd2, 4'd3, 1'b1, 15'h1234, 1'b0, "uni");
    chk("uni.data_const", data_out_i_in, 32'h0023_9234);
    pop1("uni.pop");
    chk("uni.tx_const", 32'(tx_count), 32'd1);
    cycle(1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 15'h0, 1'b0, "bc");
    chk("bc.data_const", data_out_i_in, 32'hFF11_0000);
    pop1("bc.pop");

    // Fill to capacity, attempt an overflow, then drain in order.
    for (int i = 0; i < 16; i++) push_p(PW'(i), "fill");
    chk("full.ready_const", 32'(in_ready), 32'd0);
    push_p(15'h7777, "overflow");
    for (int i = 0; i < 16; i++) begin
      chk("drain.order", 32'(data_out_i_in[PW-1:0]), 32'(i));
      pop1("drain");
    end
    chk("drain.pndng_const", 32'(pndng_i_in), 32'd0);

    // Pointer wrap across two bursts.
    for (int i = 0; i < 10; i++) push_p(PW'(100 + i), "wrap.push10");
    for (int i = 0; i < 10; i++) pop1("wrap.pop10");
    for (int i = 0; i < 12; i++) push_p(PW'(200 + i), "wrap.push12");
    for (int i = 0; i < 12; i++) pop1("wrap.pop12");
    chk("wrap.level_const", 32'(level), 32'd0);

    // Simultaneous push/pop in steady state, then at full.
    for (int i = 0; i < 5; i++) push_p(PW'(300 + i), "ss.fill");
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'd3, 4'd4, 1'b1, PW'(400 + i), 1'b1, "ss.both");
    chk("ss.level_const", 32'(level), 32'd5);
    for (int i = 0; i < 11; i++) push_p(PW'(500 + i), "ss.tofull");
    cycle(1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 15'h0AAA, 1'b1, "full.both");
    chk("full.both.level_const", 32'(level), 32'd15);
    while (model_q.size() != 0) pop1("ss.drain");

    // Pop on empty sets sticky error; push into empty with popin still proceeds.
    pop1("popempty");
    chk("popempty.err_const", 32'(err_pop_empty), 32'd1);
    cycle(1'b1, 1'b0, 4'd4, 4'd4, 1'b0, 15'h0055, 1'b1, "push_empty_pop");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 60), 1'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), PW'($urandom), ($urandom_range(0, 99) < 45), "rand");
    end

    // Asynchronous reset with buffered packets.
    while (model_q.size() < 7) push_p(PW'($urandom), "pre_rst");
    while (model_q.size() > 7) pop1("pre_rst");
    pop1("pre_rst.adj");
    push_p(PW'(7), "pre_rst.adj2");
    chk("pre_rst.level_const", 32'(level), 32'd7);
    #2 reset = 1'b1;
    #1;
    chk("arst.level", 32'(level), 32'd0);
    chk("arst.pndng", 32'(pndng_i_in), 32'd0);
    chk("arst.err", 32'(err_pop_empty), 32'd0);
    chk("arst.ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 1'b0, 4'd2, 4'd2, 1'b1, 15'h0001, 1'b0, "post_rst");
    pop1("post_rst.pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
